fb_pixel_writer: RTL and testbench

- Upstream stage of the VGA display path: loads one 8-bit grayscale image into the dual-port frame RAM that draw_board reads through rdaddress/q.
- Accepts a valid/ready pixel stream (UART/processor side), generates linear row-major write addresses and the RAM write strobe, and reports frame completion and framing errors.
- Sits between the image source and the RAM write port, in the same clock domain as clk.

---
 rtl/fb_pixel_writer.sv | 128 ++++++++++++
 tb/tb_fb_pixel_writer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// Frame loader: turns a valid/ready pixel stream into row-major writes on the frame RAM
// write port, with end-of-frame pulse and sticky framing-error flags.
module fb_pixel_writer #(
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 400,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic              err_short,
    output logic              err_long,
    output logic [9:0]        col,
    output logic [9:0]        row
);

    localparam int unsigned       TOTAL     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [9:0]        LAST_COL  = 10'(IMG_W - 1);
    localparam logic [9:0]        CNT_ONE   = 10'(1);

    typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [9:0]          col_cnt_reg, row_cnt_reg;
    logic [ADDR_W-1:0]   wraddress_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                wren_reg, err_short_reg, err_long_reg;
    logic [9:0]          col_reg, row_reg;
    logic                accept, at_last, load_start;

    assign accept     = s_valid && s_ready;
    assign at_last    = (addr_reg == LAST_ADDR);
    assign load_start = (state_reg == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                // The final address ends the frame whether or not s_last came with it.
                if (accept && (at_last || s_last)) state_next = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            col_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            wraddress_reg <= '0;
            data_reg      <= '0;
            wren_reg      <= 1'b0;
            col_reg       <= '0;
            row_reg       <= '0;
            err_short_reg <= 1'b0;
            err_long_reg  <= 1'b0;
        end else begin
            wren_reg <= accept;
            if (load_start) begin
                addr_reg      <= '0;
                col_cnt_reg   <= '0;
                row_cnt_reg   <= '0;
                err_short_reg <= 1'b0;
                err_long_reg  <= 1'b0;
            end else if (accept) begin
                wraddress_reg <= addr_reg;
                data_reg      <= s_data;
                col_reg       <= col_cnt_reg;
                row_reg       <= row_cnt_reg;
                // Counters park on the final pixel so the address never runs past the image.
                if (!at_last) begin
                    addr_reg <= addr_reg + ADDR_ONE;
                    if (col_cnt_reg == LAST_COL) begin
                        col_cnt_reg <= '0;
                        row_cnt_reg <= row_cnt_reg + CNT_ONE;
                    end else begin
                        col_cnt_reg <= col_cnt_reg + CNT_ONE;
                    end
                end
                if (s_last && !at_last) err_short_reg <= 1'b1;
                if (at_last && !s_last) err_long_reg  <= 1'b1;
            end
        end
    end

    assign wraddress = wraddress_reg;
    assign data      = data_reg;
    assign wren      = wren_reg;
    assign col       = col_reg;
    assign row       = row_reg;
    assign err_short = err_short_reg;
    assign err_long  = err_long_reg;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer on a 400x4 image (full-width rows, short frame).
module tb_fb_pixel_writer;

    localparam int IMG_W = 400;
    localparam int IMG_H = 4;
    localparam int TOTAL = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_ready, wren, busy, done, err_short, err_long;
    logic [17:0] wraddress;
    logic [7:0]  data;
    logic [9:0]  col, row;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fb_pixel_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(18), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .wraddress(wraddress), .data(data),
        .wren(wren), .busy(busy), .done(done), .err_short(err_short),
        .err_long(err_long), .col(col), .row(row)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
    endtask

    task automatic do_start(input string tag);
        drive(1'b0, 8'h00, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({s_ready, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s_enter_load: got ready/busy=%b want 11", tag, {s_ready, busy});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if ({s_ready, wren, busy, done, wraddress, data, col, row, err_short, err_long} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b wren=%b busy=%b done=%b addr=%0d data=%h col=%0d row=%0d es=%b el=%b want all 0",
                     s_ready, wren, busy, done, wraddress, data, col, row, err_short, err_long);
        end
        $display("test_reset done");
    endtask

    task automatic test_full_frame();
        logic [48:0] got, exp;
        do_start("full");
        for (int i = 0; i < TOTAL; i++) begin
            drive(1'b1, 8'(i), i == TOTAL - 1);
            step();
            got = {wren, wraddress, data, col, row, done};
            exp = {1'b1, 18'(i), 8'(i), 10'(i % IMG_W), 10'(i / IMG_W), 1'(i == TOTAL - 1)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL full_write[%0d]: got wren=%b addr=%0d data=%h col=%0d row=%0d done=%b want addr=%0d col=%0d row=%0d done=%b",
                         i, wren, wraddress, data, col, row, done, i, i % IMG_W, i / IMG_W, i == TOTAL - 1);
            end
        end
        n_checks++;
        if ({wraddress, data, err_short, err_long} !== {18'd1599, 8'h3F, 2'b00}) begin
            n_fail++;
            $display("FAIL full_last: got addr=%0d data=%h es=%b el=%b want 1599 3f 0 0", wraddress, data, err_short, err_long);
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if ({done, wren, s_ready, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL full_after: got done/wren/ready/busy=%b want 0000", {done, wren, s_ready, busy});
        end
        $display("test_full_frame done");
    endtask

    task automatic test_gappy_source();
        int  n = 0;
        int  k = 0;
        logic v;
        do_start("gap");
        while (n < TOTAL && k < 3 * TOTAL) begin
            v = (k % 2 == 0);
            // Idle cycles carry junk data and a spurious s_last that must be ignored.
            if (v) drive(1'b1, 8'(n), n == TOTAL - 1);
            else   drive(1'b0, 8'hA5, 1'b1);
            step();
            n_checks++;
            if (v) begin
                if ({wren, wraddress, data, done} !== {1'b1, 18'(n), 8'(n), 1'(n == TOTAL - 1)}) begin
                    n_fail++;
                    $display("FAIL gap_write[%0d]: got wren=%b addr=%0d data=%h done=%b want 1 %0d %h %b",
                             n, wren, wraddress, data, done, n, 8'(n), n == TOTAL - 1);
                end
                n++;
            end else if ({wren, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL gap_idle[%0d]: got wren/done=%b want 00", k, {wren, done});
            end
            k++;
        end
        n_checks++;
        if (n != TOTAL || err_short !== 1'b0 || err_long !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_total: got writes=%0d es=%b el=%b want %0d 0 0", n, err_short, err_long, TOTAL);
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        $display("test_gappy_source done");
    endtask

    task automatic test_short_frame();
        do_start("short");
        for (int i = 0; i < IMG_W; i++) begin
            drive(1'b1, 8'(i), i == IMG_W - 1);
            step();
        end
        n_checks++;
        if ({wren, wraddress, col, row, err_short, err_long, done} !== {1'b1, 18'd399, 10'd399, 10'd0, 3'b101}) begin
            n_fail++;
            $display("FAIL short_last: got wren=%b addr=%0d col=%0d row=%0d es=%b el=%b done=%b want 1 399 399 0 1 0 1",
                     wren, wraddress, col, row, err_short, err_long, done);
        end
        drive(1'b1, 8'h55, 1'b0);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL short_ready: got %b want 0", s_ready);
        end
        step();
        n_checks++;
        if ({wren, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL short_extra: got wren/done=%b want 00", {wren, done});
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        n_checks++;
        if (err_short !== 1'b1) begin
            n_fail++;
            $display("FAIL short_sticky: got %b want 1", err_short);
        end
        $display("test_short_frame done");
    endtask

    task automatic test_long_frame();
        do_start("long");
        n_checks++;
        if ({err_short, err_long} !== 2'b00) begin
            n_fail++;
            $display("FAIL long_clear: got es/el=%b want 00", {err_short, err_long});
        end
        for (int i = 0; i < TOTAL; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            step();
        end
        n_checks++;
        if ({wren, wraddress, err_long, err_short, done} !== {1'b1, 18'd1599, 3'b101}) begin
            n_fail++;
            $display("FAIL long_last: got wren=%b addr=%0d el=%b es=%b done=%b want 1 1599 1 0 1",
                     wren, wraddress, err_long, err_short, done);
        end
        drive(1'b1, 8'hEE, 1'b0);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL long_ready: got %b want 0", s_ready);
        end
        step();
        n_checks++;
        if ({wren, wraddress} !== {1'b0, 18'd1599}) begin
            n_fail++;
            $display("FAIL long_extra: got wren=%b addr=%0d want 0 1599", wren, wraddress);
        end
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (err_long !== 1'b1) begin
            n_fail++;
            $display("FAIL long_sticky: got %b want 1", err_long);
        end
        $display("test_long_frame done");
    endtask

    task automatic test_reset_mid_frame();
        do_start("rst");
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            step();
        end
        n_checks++;
        if ({wraddress, col, row} !== {18'd999, 10'd199, 10'd2}) begin
            n_fail++;
            $display("FAIL rst_pre: got addr=%0d col=%0d row=%0d want 999 199 2", wraddress, col, row);
        end
        reset = 1'b1;
        drive(1'b1, 8'hCC, 1'b1);
        step();
        reset = 1'b0;
        n_checks++;
        if ({s_ready, wren, busy, done, wraddress, data, col, row, err_short, err_long} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got ready=%b wren=%b busy=%b done=%b addr=%0d data=%h col=%0d row=%0d want all 0",
                     s_ready, wren, busy, done, wraddress, data, col, row);
        end
        step();
        n_checks++;
        if ({wren, s_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_idle: got wren/ready=%b want 00", {wren, s_ready});
        end
        do_start("rst2");
        drive(1'b1, 8'h11, 1'b0);
        step();
        n_checks++;
        if ({wren, wraddress, data, err_short, err_long} !== {1'b1, 18'd0, 8'h11, 2'b00}) begin
            n_fail++;
            $display("FAIL rst_restart: got wren=%b addr=%0d data=%h es=%b el=%b want 1 0 11 0 0",
                     wren, wraddress, data, err_short, err_long);
        end
        for (int i = 1; i < 10; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            start = (i == 5);
            step();
            start = 1'b0;
            n_checks++;
            if ({wren, wraddress, col, row} !== {1'b1, 18'(i), 10'(i), 10'd0}) begin
                n_fail++;
                $display("FAIL start_in_load[%0d]: got wren=%b addr=%0d col=%0d row=%0d want 1 %0d %0d 0",
                         i, wren, wraddress, col, row, i, i);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gappy_source();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
